dmem_wait: RTL

//   Parametrised data memory with a req/ready request handshake and a one-cycle rvalid response.
//   It has per-byte write enables and a configurable access latency.

---
 rtl/dmem_wait_if.sv | 24 ++
 rtl/dmem_wait.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_wait_if.sv
// Request/response bus for the wait-state data memory.
//
// Handshake: the master holds req (with we/be/a/wd) and a request is
// accepted on a rising edge where req & ready are both high. The payload
// is sampled only on that edge. The slave answers with a single-cycle
// rvalid strobe; rd/err are meaningful while rvalid is high and hold their
// values until the next response. There is no back-pressure on responses.
interface dmem_wait_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            req;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   a;
  logic [DW-1:0]   wd;
  logic            ready;
  logic            rvalid;
  logic [DW-1:0]   rd;
  logic            err;

  modport master (output req, we, be, a, wd, input ready, rvalid, rd, err);
  modport slave  (input req, we, be, a, wd, output ready, rvalid, rd, err);
endinterface

// File: rtl/dmem_wait.sv
// Word-organised data memory with a configurable access latency, per-byte
// write enables and an error flag for misaligned or out-of-range accesses.
module dmem_wait #(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 64,
  parameter int    AW        = 32,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         reset,
  dmem_wait_if.slave   bus,
  output logic [1:0]   dbg_state_o
);
  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [AW-1:0] OFS_MASK = AW'((1 << OFS) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q, rvalid_q, err_q;
  logic [DW-1:0] rd_q;
  logic          we_q;
  logic [NB-1:0] be_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] wd_q;

  logic          accept, resp_now, bad, wr_en;
  logic          op_we;
  logic [NB-1:0] op_be;
  logic [AW-1:0] op_a, idx_full;
  logic [DW-1:0] op_wd;
  logic [IW-1:0] idx_w;

  // With a single-cycle latency the response edge is the accepting edge,
  // so the operation comes straight from the bus instead of the capture regs.
  always_comb begin
    op_we = we_q;
    op_be = be_q;
    op_a  = a_q;
    op_wd = wd_q;
    if (LATENCY == 1) begin
      op_we = bus.we;
      op_be = bus.be;
      op_a  = bus.a;
      op_wd = bus.wd;
    end
  end

  assign accept   = (state_q != S_WAIT) && bus.req;
  assign resp_now = ((LATENCY == 1) && accept) || ((state_q == S_WAIT) && (cnt_q == '0));
  assign idx_full = op_a >> OFS;
  assign idx_w    = idx_full[IW-1:0];
  assign bad      = ((op_a & OFS_MASK) != '0) || (idx_full >= AW'(DEPTH));
  // reset gating keeps an aborted request from committing while reset is low
  assign wr_en    = resp_now && op_we && !bad && reset;

  // Byte-masked write, committed on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (op_be[i]) mem[idx_w][8*i +: 8] <= op_wd[8*i +: 8];
      end
    end
  end

  // Request FSM with registered handshake, response strobe and read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      a_q      <= '0;
      wd_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (resp_now) begin
        rvalid_q <= 1'b1;
        err_q    <= bad;
        rd_q     <= (bad || op_we) ? '0 : mem[idx_w];
      end
      case (state_q)
        S_IDLE, S_RESP: begin
          if (bus.req) begin
            we_q <= bus.we;
            be_q <= bus.be;
            a_q  <= bus.a;
            wd_q <= bus.wd;
            if (LATENCY == 1) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rd      = rd_q;
  assign bus.err     = err_q;
  assign dbg_state_o = state_q;
endmodule
